// File: rtl/arbitro_multiplicador_pkg.sv
// Shared widths and FSM encoding for the round-robin multiplier arbiter.
package paquete_arbitro_mult;

  localparam int ANCHO_OPERANDO = 4;
  localparam int ANCHO_PRODUCTO = 8;

  typedef enum logic [1:0] {
    LIBRE   = 2'b00,
    CALCULO = 2'b01,
    ENTREGA = 2'b10
  } estado_e;

endpackage

// File: rtl/arbitro_multiplicador_multiplicador.sv
// Unsigned 4x4 array multiplier: AND partial products accumulated by a shift-add chain.
module Multiplicador4_Bits
  import paquete_arbitro_mult::*;
(
  input  logic [ANCHO_OPERANDO-1:0] Multiplicando,
  input  logic [ANCHO_OPERANDO-1:0] Multiplicador,
  output logic [ANCHO_PRODUCTO-1:0] Producto
);

  logic [ANCHO_OPERANDO-1:0] parcial_s [ANCHO_OPERANDO];
  logic [ANCHO_PRODUCTO-1:0] suma_s    [ANCHO_OPERANDO+1];

  assign suma_s[0] = {ANCHO_PRODUCTO{1'b0}};

  for (genvar i = 0; i < ANCHO_OPERANDO; i++) begin : g_fila
    assign parcial_s[i] = Multiplicando & {ANCHO_OPERANDO{Multiplicador[i]}};
    assign suma_s[i+1]  = suma_s[i] + (ANCHO_PRODUCTO'(parcial_s[i]) << i);
  end

  assign Producto = suma_s[ANCHO_OPERANDO];

endmodule

// File: rtl/arbitro_multiplicador.sv
// Round-robin arbiter sharing one 4x4 multiplier among NUM_SOLICITANTES clients,
// delivering each product on a Valido/Listo result channel.
module arbitro_multiplicador
  import paquete_arbitro_mult::*;
#(
  parameter int NUM_SOLICITANTES = 4,
  parameter int ANCHO_ID         = 2
) (
  input  logic                                   Reloj,
  input  logic                                   Reinicio,
  input  logic [NUM_SOLICITANTES-1:0]            Solicitud,
  input  logic [ANCHO_OPERANDO*NUM_SOLICITANTES-1:0] OperandoX,
  input  logic [ANCHO_OPERANDO*NUM_SOLICITANTES-1:0] OperandoY,
  output logic [NUM_SOLICITANTES-1:0]            Concesion,
  output logic [ANCHO_PRODUCTO-1:0]              Resultado,
  output logic [ANCHO_ID-1:0]                    Destino,
  output logic                                   Valido,
  input  logic                                   Listo,
  output logic                                   Ocupado
);

  estado_e                       estado_q;
  logic [ANCHO_ID-1:0]           puntero_q;
  logic [ANCHO_ID-1:0]           ganador_q;
  logic [ANCHO_OPERANDO-1:0]     x_q;
  logic [ANCHO_OPERANDO-1:0]     y_q;
  logic [NUM_SOLICITANTES-1:0]   concesion_q;
  logic [ANCHO_PRODUCTO-1:0]     resultado_q;
  logic [ANCHO_ID-1:0]           destino_q;
  logic                          valido_q;
  logic                          ocupado_q;

  logic                          sel_valido_s;
  logic [ANCHO_ID-1:0]           sel_idx_s;
  logic [ANCHO_ID-1:0]           cand_s;
  logic [ANCHO_OPERANDO-1:0]     x_sel_s;
  logic [ANCHO_OPERANDO-1:0]     y_sel_s;
  logic [ANCHO_PRODUCTO-1:0]     producto_s;
  logic [ANCHO_ID-1:0]           puntero_sig_s;

  // First requester at or after the pointer, wrapping past the last index.
  always_comb begin
    sel_valido_s = 1'b0;
    sel_idx_s    = {ANCHO_ID{1'b0}};
    cand_s       = {ANCHO_ID{1'b0}};
    for (int k = 0; k < NUM_SOLICITANTES; k++) begin
      cand_s = ANCHO_ID'((int'(puntero_q) + k) % NUM_SOLICITANTES);
      if (!sel_valido_s && Solicitud[cand_s]) begin
        sel_valido_s = 1'b1;
        sel_idx_s    = cand_s;
      end else begin
        sel_valido_s = sel_valido_s;
      end
    end
  end

  // Operand slice of the selected requester.
  always_comb begin
    x_sel_s = {ANCHO_OPERANDO{1'b0}};
    y_sel_s = {ANCHO_OPERANDO{1'b0}};
    for (int i = 0; i < NUM_SOLICITANTES; i++) begin
      if (sel_idx_s == ANCHO_ID'(i)) begin
        x_sel_s = OperandoX[ANCHO_OPERANDO*i +: ANCHO_OPERANDO];
        y_sel_s = OperandoY[ANCHO_OPERANDO*i +: ANCHO_OPERANDO];
      end else begin
        x_sel_s = x_sel_s;
        y_sel_s = y_sel_s;
      end
    end
  end

  assign puntero_sig_s = (ganador_q == ANCHO_ID'(NUM_SOLICITANTES - 1)) ?
                         {ANCHO_ID{1'b0}} : ganador_q + ANCHO_ID'(1);

  Multiplicador4_Bits u_multiplicador (
    .Multiplicando (x_q),
    .Multiplicador (y_q),
    .Producto      (producto_s)
  );

  // Arbitration FSM; the multiplier only ever sees the operands latched at the grant.
  always_ff @(posedge Reloj) begin
    if (Reinicio) begin
      estado_q    <= LIBRE;
      puntero_q   <= {ANCHO_ID{1'b0}};
      ganador_q   <= {ANCHO_ID{1'b0}};
      x_q         <= {ANCHO_OPERANDO{1'b0}};
      y_q         <= {ANCHO_OPERANDO{1'b0}};
      concesion_q <= {NUM_SOLICITANTES{1'b0}};
      resultado_q <= {ANCHO_PRODUCTO{1'b0}};
      destino_q   <= {ANCHO_ID{1'b0}};
      valido_q    <= 1'b0;
      ocupado_q   <= 1'b0;
    end else begin
      concesion_q <= {NUM_SOLICITANTES{1'b0}};
      case (estado_q)
        LIBRE: begin
          if (sel_valido_s) begin
            x_q         <= x_sel_s;
            y_q         <= y_sel_s;
            ganador_q   <= sel_idx_s;
            concesion_q <= {{(NUM_SOLICITANTES-1){1'b0}}, 1'b1} << sel_idx_s;
            ocupado_q   <= 1'b1;
            estado_q    <= CALCULO;
          end
        end
        CALCULO: begin
          resultado_q <= producto_s;
          destino_q   <= ganador_q;
          valido_q    <= 1'b1;
          estado_q    <= ENTREGA;
        end
        ENTREGA: begin
          if (Listo) begin
            valido_q  <= 1'b0;
            ocupado_q <= 1'b0;
            puntero_q <= puntero_sig_s;
            estado_q  <= LIBRE;
          end
        end
        default: begin
          valido_q  <= 1'b0;
          ocupado_q <= 1'b0;
          estado_q  <= LIBRE;
        end
      endcase
    end
  end

  assign Concesion = concesion_q;
  assign Resultado = resultado_q;
  assign Destino   = destino_q;
  assign Valido    = valido_q;
  assign Ocupado   = ocupado_q;

endmodule

// File: tb/tb_arbitro_multiplicador.sv
// Randomized transaction-level bench for arbitro_multiplicador with a round-robin reference model.
module tb_arbitro_multiplicador;

  localparam int N = 4;

  logic           Reloj = 1'b0;
  logic           Reinicio;
  logic [N-1:0]   Solicitud;
  logic [4*N-1:0] OperandoX;
  logic [4*N-1:0] OperandoY;
  logic [N-1:0]   Concesion;
  logic [7:0]     Resultado;
  logic [1:0]     Destino;
  logic           Valido;
  logic           Listo;
  logic           Ocupado;

  int chk_cnt = 0;
  int ok_cnt  = 0;
  int puntero_m = 0;
  int xs [N];
  int ys [N];

  arbitro_multiplicador #(.NUM_SOLICITANTES(N), .ANCHO_ID(2)) dut (
    .Reloj     (Reloj),
    .Reinicio  (Reinicio),
    .Solicitud (Solicitud),
    .OperandoX (OperandoX),
    .OperandoY (OperandoY),
    .Concesion (Concesion),
    .Resultado (Resultado),
    .Destino   (Destino),
    .Valido    (Valido),
    .Listo     (Listo),
    .Ocupado   (Ocupado)
  );

  always #5 Reloj = ~Reloj;

  task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    chk_cnt++;
    if (obs === esp) ok_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
  endtask

  task automatic ciclo;
    @(posedge Reloj);
    #1;
  endtask

  task automatic aplicar_operandos;
    for (int i = 0; i < N; i++) begin
      OperandoX[4*i +: 4] = 4'(xs[i]);
      OperandoY[4*i +: 4] = 4'(ys[i]);
    end
  endtask

  function automatic int ganador(input int mascara, input int p);
    for (int k = 0; k < N; k++) begin
      if (((mascara >> ((p + k) % N)) & 1) != 0) return (p + k) % N;
    end
    return -1;
  endfunction

  // One full request/grant/result/accept exchange; nuevo>=0 overwrites all operands after the grant.
  task automatic transaccion(input int mascara, input int espera, input int nuevo);
    int g;
    int esp;
    g = ganador(mascara, puntero_m);
    esp = xs[g] * ys[g];
    Solicitud = N'(mascara);
    aplicar_operandos();
    Listo = 1'b0;
    ciclo();
    chequear("concesion", 32'(Concesion), 32'(1 << g));
    chequear("ocupado_conc", 32'(Ocupado), 32'd1);
    chequear("valido_conc", 32'(Valido), 32'd0);
    Solicitud = '0;
    if (nuevo >= 0) begin
      for (int i = 0; i < N; i++) begin
        xs[i] = nuevo;
        ys[i] = nuevo;
      end
      aplicar_operandos();
    end
    ciclo();
    chequear("valido", 32'(Valido), 32'd1);
    chequear("resultado", 32'(Resultado), 32'(esp));
    chequear("destino", 32'(Destino), 32'(g));
    chequear("concesion_calc", 32'(Concesion), 32'd0);
    for (int h = 0; h < espera; h++) begin
      Solicitud = N'($urandom_range(1, 15));
      ciclo();
      chequear("valido_espera", 32'(Valido), 32'd1);
      chequear("resultado_espera", 32'(Resultado), 32'(esp));
      chequear("destino_espera", 32'(Destino), 32'(g));
      chequear("concesion_espera", 32'(Concesion), 32'd0);
    end
    Solicitud = '0;
    Listo = 1'b1;
    ciclo();
    chequear("valido_acept", 32'(Valido), 32'd0);
    chequear("ocupado_acept", 32'(Ocupado), 32'd0);
    Listo = 1'b0;
    puntero_m = (g + 1) % N;
  endtask

  task automatic reiniciar;
    Reinicio = 1'b1;
    ciclo();
    Reinicio = 1'b0;
    puntero_m = 0;
  endtask

  initial begin
    int g;
    int m;
    Reinicio  = 1'b1;
    Solicitud = '0;
    OperandoX = '0;
    OperandoY = '0;
    Listo     = 1'b0;
    ciclo();
    ciclo();
    chequear("rst_concesion", 32'(Concesion), 32'd0);
    chequear("rst_resultado", 32'(Resultado), 32'd0);
    chequear("rst_destino", 32'(Destino), 32'd0);
    chequear("rst_valido", 32'(Valido), 32'd0);
    chequear("rst_ocupado", 32'(Ocupado), 32'd0);
    Reinicio = 1'b0;
    ciclo();
    chequear("libre_ocupado", 32'(Ocupado), 32'd0);

    // Basic 3x5 on requester 0, then extremes.
    xs = '{3, 0, 0, 0}; ys = '{5, 0, 0, 0};
    transaccion(1, 0, -1);
    xs = '{0, 15, 0, 0}; ys = '{0, 15, 0, 0};
    transaccion(2, 0, -1);
    xs = '{0, 0, 0, 0}; ys = '{0, 0, 9, 0};
    transaccion(4, 0, -1);

    // Five-cycle hold with Listo low, then operands overwritten after the grant.
    xs = '{4, 6, 7, 11}; ys = '{13, 2, 8, 14};
    transaccion(15, 5, -1);
    xs = '{2, 2, 2, 2}; ys = '{7, 7, 7, 7};
    transaccion(15, 0, 9);

    // Continuous requests from all, Listo high: grant order 0,1,2,3,0 every 3 cycles.
    reiniciar();
    xs = '{5, 6, 7, 8}; ys = '{9, 10, 11, 12};
    aplicar_operandos();
    Solicitud = 4'b1111;
    Listo = 1'b1;
    for (int t = 0; t < 5; t++) begin
      g = t % N;
      ciclo();
      chequear("rr_concesion", 32'(Concesion), 32'(1 << g));
      ciclo();
      chequear("rr_valido", 32'(Valido), 32'd1);
      chequear("rr_resultado", 32'(Resultado), 32'(xs[g] * ys[g]));
      chequear("rr_destino", 32'(Destino), 32'(g));
      ciclo();
      chequear("rr_acept", 32'(Valido), 32'd0);
      chequear("rr_sin_conc", 32'(Concesion), 32'd0);
    end
    Solicitud = '0;
    Listo = 1'b0;
    ciclo();
    puntero_m = 1;

    // Reset during CALCULO discards the operation and returns the pointer to 0.
    xs = '{1, 2, 3, 4}; ys = '{5, 6, 7, 8};
    aplicar_operandos();
    Solicitud = 4'b0100;
    ciclo();
    chequear("pre_rst_conc", 32'(Concesion), 32'b0100);
    Solicitud = '0;
    Reinicio = 1'b1;
    ciclo();
    Reinicio = 1'b0;
    puntero_m = 0;
    chequear("rst_mid_valido", 32'(Valido), 32'd0);
    chequear("rst_mid_conc", 32'(Concesion), 32'd0);
    chequear("rst_mid_ocupado", 32'(Ocupado), 32'd0);
    Listo = 1'b1;
    ciclo();
    ciclo();
    chequear("rst_mid_sin_valido", 32'(Valido), 32'd0);
    Listo = 1'b0;
    transaccion(10, 1, -1);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) begin
        xs[i] = $urandom_range(0, 15);
        ys[i] = $urandom_range(0, 15);
      end
      m = $urandom_range(1, 15);
      transaccion(m, $urandom_range(0, 4), ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : -1);
    end

    $display("%0d/%0d checks passed", ok_cnt, chk_cnt);
    $finish;
  end

endmodule
